// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage
//  wsel_e  : destination-data select encoding (alu, mem, pc, illegal)
//  PSR_*   : {N,Z,P} condition-code encodings, PSR_RST is the reset value
package wb_pkg;
    typedef enum logic [1:0] {WSEL_ALU, WSEL_MEM, WSEL_PC, WSEL_ILL} wsel_e;
    localparam logic [2:0] PSR_N   = 3'b100;
    localparam logic [2:0] PSR_Z   = 3'b010;
    localparam logic [2:0] PSR_P   = 3'b001;
    localparam logic [2:0] PSR_RST = PSR_Z;
endpackage

// File: rtl/wb_regfile.sv
// wb_regfile: NREG x DW register file, one sync write port, NRD async read ports
//  clk, rst          : clock, synchronous active-high reset (clears all registers)
//  we, waddr, wdata  : write port
//  rd_addr, rd_data  : flattened read ports, port i at [i*AW +: AW] / [i*DW +: DW]
module wb_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data
);
    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) mem[k] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar i;
    for (i = 0; i < NRD; i++) begin : g_rd
        assign rd_data[i*DW +: DW] = mem[rd_addr[i*AW +: AW]];
    end
endmodule

// File: rtl/writeback_pipe.sv
// writeback_pipe: LC-3 writeback stage with one-entry staging, register file, PSR update
//  clk, rst                  : clock, synchronous active-high reset
//  in_valid/in_ready         : request handshake
//  aluout, memout, pcout     : candidate write data, chosen by w_sel at accept
//  w_sel, we, set_cc, dr     : request control
//  wb_hold                   : stall the staged entry
//  rd_addr/rd_data           : decode-side read ports
//  psr, wb_done, wb_dr       : commit results
//  illegal_sel, retire_cnt   : sticky illegal-select flag, commit counter
//  Option: define WB_BYPASS_EN to forward the staged write data to matching read ports.
module writeback_pipe
    import wb_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int NRD  = 2,
    parameter int CW   = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     aluout,
    input  logic [DW-1:0]     memout,
    input  logic [DW-1:0]     pcout,
    input  logic [1:0]        w_sel,
    input  logic              we,
    input  logic              set_cc,
    input  logic [AW-1:0]     dr,
    input  logic              wb_hold,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [2:0]        psr,
    output logic              wb_done,
    output logic [AW-1:0]     wb_dr,
    output logic              illegal_sel,
    output logic [CW-1:0]     retire_cnt
);
    logic              stg_valid, stg_we, stg_cc, stg_ill;
    logic [AW-1:0]     stg_dr;
    logic [DW-1:0]     stg_data, sel_data;
    logic [2:0]        cc_next;
    logic [NRD*DW-1:0] rf_rd;
    logic              commit, accept;
    wsel_e             sel;

    assign sel      = wsel_e'(w_sel);
    assign commit   = stg_valid && !wb_hold;
    assign in_ready = !stg_valid || commit;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sel_data = sel == WSEL_MEM ? memout : sel == WSEL_PC ? pcout : aluout;
        cc_next  = stg_data[DW-1] ? PSR_N : stg_data == '0 ? PSR_Z : PSR_P;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid   <= 1'b0;
            stg_we      <= 1'b0;
            stg_cc      <= 1'b0;
            stg_ill     <= 1'b0;
            stg_dr      <= '0;
            stg_data    <= '0;
            psr         <= PSR_RST;
            wb_done     <= 1'b0;
            wb_dr       <= '0;
            illegal_sel <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            if (accept) begin
                stg_valid <= 1'b1;
                stg_we    <= we;
                stg_cc    <= set_cc;
                stg_ill   <= sel == WSEL_ILL;
                stg_dr    <= dr;
                stg_data  <= sel_data;
            end else if (commit) begin
                stg_valid <= 1'b0;
            end
            wb_done <= commit;
            if (commit) begin
                wb_dr      <= stg_dr;
                retire_cnt <= retire_cnt + CW'(1);
                if (stg_ill) illegal_sel <= 1'b1;
                else if (stg_cc) psr <= cc_next;
            end
        end
    end

    wb_regfile #(.DW(DW), .NREG(NREG), .NRD(NRD)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (commit && stg_we && !stg_ill),
        .waddr   (stg_dr),
        .wdata   (stg_data),
        .rd_addr (rd_addr),
        .rd_data (rf_rd)
    );

`ifdef WB_BYPASS_EN
    // Forward even while held so decode never sees a value older than the staged write.
    genvar i;
    for (i = 0; i < NRD; i++) begin : g_byp
        assign rd_data[i*DW +: DW] =
            (stg_valid && stg_we && !stg_ill && rd_addr[i*AW +: AW] == stg_dr)
                ? stg_data : rf_rd[i*DW +: DW];
    end
`else
    assign rd_data = rf_rd;
`endif
endmodule

// File: tb/tb_writeback_pipe.sv
// tb_writeback_pipe: directed self-checking bench for writeback_pipe (CW=16 and CW=4 instances)
module tb_writeback_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, we, set_cc, wb_hold;
    logic [15:0] aluout, memout, pcout;
    logic [1:0]  w_sel;
    logic [2:0]  dr;
    logic [5:0]  rd_addr;
    logic        in_ready, wb_done, illegal_sel;
    logic [31:0] rd_data;
    logic [2:0]  psr, wb_dr;
    logic [15:0] retire_cnt;
    logic        in_ready4, wb_done4, illegal_sel4;
    logic [31:0] rd_data4;
    logic [2:0]  psr4, wb_dr4;
    logic [3:0]  retire_cnt4;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    writeback_pipe #(.DW(16), .NREG(8), .NRD(2), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluout(aluout), .memout(memout), .pcout(pcout), .w_sel(w_sel),
        .we(we), .set_cc(set_cc), .dr(dr), .wb_hold(wb_hold),
        .rd_addr(rd_addr), .rd_data(rd_data), .psr(psr), .wb_done(wb_done),
        .wb_dr(wb_dr), .illegal_sel(illegal_sel), .retire_cnt(retire_cnt)
    );

    writeback_pipe #(.DW(16), .NREG(8), .NRD(2), .CW(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .aluout(aluout), .memout(memout), .pcout(pcout), .w_sel(w_sel),
        .we(we), .set_cc(set_cc), .dr(dr), .wb_hold(wb_hold),
        .rd_addr(rd_addr), .rd_data(rd_data4), .psr(psr4), .wb_done(wb_done4),
        .wb_dr(wb_dr4), .illegal_sel(illegal_sel4), .retire_cnt(retire_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic req(input logic [1:0] s, input logic w, input logic c, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] m, input logic [15:0] p);
        in_valid = 1'b1; w_sel = s; we = w; set_cc = c; dr = d;
        aluout = a; memout = m; pcout = p;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; we = 1'b0; set_cc = 1'b0; wb_hold = 1'b0;
        aluout = '0; memout = '0; pcout = '0; w_sel = '0; dr = '0; rd_addr = '0;
        tick(); tick();
        rd(3, 5);
        check("rst_in_ready", in_ready, 1);
        check("rst_psr", psr, 3'b010);
        check("rst_wb_done", wb_done, 0);
        check("rst_wb_dr", wb_dr, 0);
        check("rst_illegal", illegal_sel, 0);
        check("rst_cnt", retire_cnt, 0);
        check("rst_r3", rd_data[15:0], 16'h0000);
        rst = 1'b0;

        req(2'd0, 1, 1, 3'd3, 16'h8001, 16'h1111, 16'h2222);
        tick();
        in_valid = 1'b0;
        check("t1_stage_no_done", wb_done, 0);
        tick();
        rd(0, 3);
        check("t1_done", wb_done, 1);
        check("t1_wb_dr", wb_dr, 3);
        check("t1_psr", psr, 3'b100);
        check("t1_cnt", retire_cnt, 1);
        check("t1_r3", rd_data[31:16], 16'h8001);

        req(2'd1, 1, 1, 3'd1, 16'h5555, 16'h0000, 16'h6666);
        tick();
        check("t2_ready_a", in_ready, 1);
        req(2'd2, 1, 0, 3'd2, 16'h7777, 16'h8888, 16'h3000);
        #1;
        check("t2_ready_b", in_ready, 1);
        tick();
        in_valid = 1'b0;
        rd(1, 2);
        check("t2_done1", wb_done, 1);
        check("t2_wb_dr1", wb_dr, 1);
        check("t2_psr1", psr, 3'b010);
        check("t2_r1", rd_data[15:0], 16'h0000);
        check("t2_ready_c", in_ready, 1);
        tick();
        rd(1, 2);
        check("t2_done2", wb_done, 1);
        check("t2_wb_dr2", wb_dr, 2);
        check("t2_psr2", psr, 3'b010);
        check("t2_r2", rd_data[31:16], 16'h3000);
        check("t2_cnt", retire_cnt, 3);

        req(2'd0, 1, 1, 3'd6, 16'h00ff, 16'h0000, 16'h0000);
        tick();
        in_valid = 1'b0; wb_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd(0, 6);
            check("t3_hold_ready", in_ready, 0);
`ifdef WB_BYPASS_EN
            check("t3_hold_r6", rd_data[31:16], 16'h00ff);
`else
            check("t3_hold_r6", rd_data[31:16], 16'h0000);
`endif
            tick();
            check("t3_hold_done", wb_done, 0);
        end
        check("t3_hold_cnt", retire_cnt, 3);
        wb_hold = 1'b0;
        #1;
        check("t3_release_ready", in_ready, 1);
        tick();
        rd(0, 6);
        check("t3_done", wb_done, 1);
        check("t3_wb_dr", wb_dr, 6);
        check("t3_psr", psr, 3'b001);
        check("t3_r6", rd_data[31:16], 16'h00ff);
        check("t3_cnt", retire_cnt, 4);

        req(2'd3, 1, 1, 3'd5, 16'hffff, 16'hffff, 16'hffff);
        tick();
        in_valid = 1'b0;
        tick();
        rd(5, 0);
        check("t4_done", wb_done, 1);
        check("t4_illegal", illegal_sel, 1);
        check("t4_psr", psr, 3'b001);
        check("t4_r5", rd_data[15:0], 16'h0000);
        check("t4_cnt", retire_cnt, 5);
        tick();
        check("t4_illegal_sticky", illegal_sel, 1);
        check("t4_done_pulse", wb_done, 0);

        req(2'd0, 1, 0, 3'd4, 16'h1111, 16'h0000, 16'h0000);
        tick();
        req(2'd1, 1, 0, 3'd4, 16'h0000, 16'h1234, 16'h0000);
        tick();
        in_valid = 1'b0; wb_hold = 1'b1;
        rd(4, 3);
`ifdef WB_BYPASS_EN
        check("t6_bypass_r4", rd_data[15:0], 16'h1234);
`else
        check("t6_bypass_r4", rd_data[15:0], 16'h1111);
`endif
        check("t6_nohit_r3", rd_data[31:16], 16'h8001);
        tick();
        wb_hold = 1'b0;
        tick();
        rd(4, 4);
        check("t6_after_p0", rd_data[15:0], 16'h1234);
        check("t6_after_p1", rd_data[31:16], 16'h1234);
        check("t6_cnt", retire_cnt, 7);

        req(2'd0, 1, 1, 3'd7, 16'h7777, 16'h0000, 16'h0000);
        tick();
        wb_hold = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; wb_hold = 1'b0; in_valid = 1'b0;
        tick(); tick();
        rd(7, 3);
        check("t5_r7", rd_data[15:0], 16'h0000);
        check("t5_r3", rd_data[31:16], 16'h0000);
        check("t5_psr", psr, 3'b010);
        check("t5_illegal", illegal_sel, 0);
        check("t5_cnt", retire_cnt, 0);
        check("t5_done", wb_done, 0);
        check("t5_wb_dr", wb_dr, 0);
        check("t5_ready", in_ready, 1);

        req(2'd0, 0, 0, 3'd0, 16'h4321, 16'h0000, 16'h0000);
        for (int k = 0; k < 17; k++) tick();
        in_valid = 1'b0;
        tick();
        rd(0, 0);
        check("cnt16_17", retire_cnt, 17);
        check("cnt4_wrap", retire_cnt4, 1);
        check("cnt_psr", psr, 3'b010);
        check("cnt_r0", rd_data[15:0], 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
